// File: rtl/vid_fetch_sched_fta256_pkg.sv
// Shared types for the video line-fetch scheduler.
// State enum, slot entry, fta bus request/response bundles.
package fta_vid_pkg;

  localparam int unsigned VFS_WORD_BYTES = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } vfs_state_t;

  typedef struct packed {
    logic       vld;
    logic [5:0] idx;
  } vfs_slot_t;

  typedef enum logic [1:0] {
    OKAY,
    DECERR,
    PROTERR,
    ERR
  } fta_err_t;

  typedef struct packed {
    logic [3:0] channel;
    logic [3:0] tranid;
  } fta_tid_t;

  typedef struct packed {
    logic        cyc;
    logic        we;
    logic [31:0] sel;
    logic [31:0] padr;
    fta_tid_t    tid;
  } fta_req_t;

  typedef struct packed {
    logic         ack;
    logic         stall;
    fta_err_t     err;
    fta_tid_t     tid;
    logic [255:0] dat;
  } fta_resp_t;

endpackage

// File: rtl/vid_fetch_sched_fta256_if.sv
// fta 256-bit bus: req from master, resp from slave.
// Ports: master(out req, in resp), slave(in req, out resp).
interface fta_bus_interface;
  import fta_vid_pkg::*;

  fta_req_t  req;
  fta_resp_t resp;

  modport master(output req, input resp);
  modport slave(input req, output resp);
endinterface

// File: rtl/edge_det.sv
// Level-to-pulse rising edge detector.
// Ports: clk, rst, i (level in), pe (rising-edge pulse, same cycle).
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i,
  output logic pe
);
  logic q;

  always_ff @(posedge clk or posedge rst)
    if (rst) q <= 1'b0;
    else     q <= i;

  assign pe = i & ~q;
endmodule

// File: rtl/vid_fetch_sched_fta256_slot_tbl.sv
// Outstanding-read slot table: tag -> line word index.
// Ports: alloc/alloc_idx, free_en/free_slot, lk_slot/lk, avail/avail_slot.
module vfs_slot_tbl
  import fta_vid_pkg::*;
#(
  parameter int MAX_OUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alloc,
  input  logic [5:0] alloc_idx,
  input  logic       free_en,
  input  logic [2:0] free_slot,
  input  logic [2:0] lk_slot,
  output vfs_slot_t  lk,
  output logic       avail,
  output logic [2:0] avail_slot
);
  vfs_slot_t tbl [MAX_OUT];

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < MAX_OUT; i++)
        tbl[i] <= '0;
    end else begin
      for (int i = 0; i < MAX_OUT; i++) begin
        if (free_en && free_slot == 3'(i))
          tbl[i].vld <= 1'b0;
        if (alloc && avail_slot == 3'(i))
          tbl[i] <= '{vld: 1'b1, idx: alloc_idx};
      end
    end

  // Descending scan so the lowest free slot wins.
  always_comb begin
    avail      = 1'b0;
    avail_slot = '0;
    lk         = '0;
    for (int i = MAX_OUT - 1; i >= 0; i--)
      if (!tbl[i].vld) begin
        avail      = 1'b1;
        avail_slot = 3'(i);
      end
    for (int i = 0; i < MAX_OUT; i++)
      if (lk_slot == 3'(i))
        lk = tbl[i];
  end
endmodule

// File: rtl/vid_fetch_sched_fta256.sv
// Line-fetch scheduler: per line_start, reads line_words 256-bit words
// over fta (m), tags by slot, writes returns to lb_* in any order.
module vid_fetch_sched_fta256
  import fta_vid_pkg::*;
#(
  parameter int         MAX_OUT = 8,
  parameter logic [3:0] CHAN    = 4'd0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         vSync,
  input  logic         line_start,
  input  logic [31:0]  base_adr,
  input  logic [15:0]  stride,
  input  logic [11:0]  vlines,
  input  logic [5:0]   line_words,
  input  logic         lb_free,
  fta_bus_interface.master m,
  output logic         lb_we,
  output logic [5:0]   lb_adr,
  output logic [255:0] lb_dat,
  output logic         line_done,
  output logic         busy,
  output logic [15:0]  overrun_cnt,
  output logic [15:0]  err_cnt
);
  vfs_state_t  state, state_nxt;
  logic [31:0] line_adr;
  logic [11:0] line_no;
  logic [5:0]  issue_idx, rcv_cnt, ld_idx;
  logic        epoch;
  logic [3:0]  outstanding;
  logic        req_cyc;
  logic [31:0] req_padr;
  fta_tid_t    req_tid;
  logic        vs_rise, avail;
  logic [2:0]  avail_slot, rsp_slot;
  vfs_slot_t   lk;
  logic        start, pend, load, accept;
  logic        own_ack, rsp_free, rsp_wr, done;

  edge_det u_vs (.clk(clk), .rst(rst), .i(vSync), .pe(vs_rise));

  assign rsp_slot = m.resp.tid.tranid[2:0];

  vfs_slot_tbl #(.MAX_OUT(MAX_OUT)) u_slots (
    .clk(clk), .rst(rst),
    .alloc(load), .alloc_idx(ld_idx),
    .free_en(rsp_free), .free_slot(rsp_slot),
    .lk_slot(rsp_slot), .lk(lk),
    .avail(avail), .avail_slot(avail_slot)
  );

  assign busy    = (state != IDLE);
  assign accept  = req_cyc & ~m.resp.stall;
  assign own_ack = m.resp.ack & (m.resp.tid.channel == CHAN);
  // Only a tag we actually hold may free a slot.
  assign rsp_free = own_ack & lk.vld;
  assign rsp_wr   = rsp_free & busy & ~vs_rise
                  & (m.resp.tid.tranid[3] == epoch);

  assign start = (state == IDLE) & line_start & en & lb_free
               & (line_no < vlines) & ~vs_rise;
  assign pend  = (state == ISSUE) & (issue_idx != line_words);
  assign ld_idx = (state == ISSUE) ? issue_idx : 6'd0;
  // The first word loads on the start edge itself.
  assign load  = (start | pend) & ~vs_rise
               & (~req_cyc | ~m.resp.stall)
               & avail & (outstanding < 4'(MAX_OUT));
  assign done  = (state == DRAIN) & (rcv_cnt == line_words) & ~vs_rise;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = ISSUE;
      ISSUE: if (accept && !load && issue_idx == line_words)
               state_nxt = DRAIN;
      DRAIN: if (rcv_cnt == line_words) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (vs_rise) state_nxt = IDLE;
  end

  always_comb begin
    m.req      = '0;
    m.req.cyc  = req_cyc;
    m.req.sel  = '1;
    m.req.padr = req_padr;
    m.req.tid  = req_tid;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      line_adr    <= '0;
      line_no     <= '0;
      issue_idx   <= '0;
      rcv_cnt     <= '0;
      epoch       <= 1'b0;
      outstanding <= '0;
      req_cyc     <= 1'b0;
      req_padr    <= '0;
      req_tid     <= '0;
      lb_we       <= 1'b0;
      lb_adr      <= '0;
      lb_dat      <= '0;
      line_done   <= 1'b0;
      overrun_cnt <= '0;
      err_cnt     <= '0;
    end else begin
      state     <= state_nxt;
      line_done <= done;
      lb_we     <= rsp_wr;
      if (rsp_wr) begin
        lb_adr <= lk.idx;
        lb_dat <= (m.resp.err == OKAY) ? m.resp.dat : '0;
      end
      if (load) begin
        req_cyc     <= 1'b1;
        req_padr    <= line_adr + 32'(ld_idx) * VFS_WORD_BYTES;
        req_tid     <= '{channel: CHAN, tranid: {epoch, avail_slot}};
        issue_idx   <= ld_idx + 6'd1;
      end else begin
        if (accept) req_cyc <= 1'b0;
        if (start)  issue_idx <= '0;
      end
      if (start)       rcv_cnt <= '0;
      else if (rsp_wr) rcv_cnt <= rcv_cnt + 6'd1;
      case ({load, rsp_free})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: ;
      endcase
      if (done) begin
        line_adr <= line_adr + 32'(stride);
        line_no  <= line_no + 12'd1;
      end
      if (vs_rise) begin
        line_no  <= '0;
        line_adr <= base_adr;
        epoch    <= ~epoch;
      end
      if (line_start && busy && !vs_rise && overrun_cnt != '1)
        overrun_cnt <= overrun_cnt + 16'd1;
      if (rsp_free && m.resp.err != OKAY && err_cnt != '1)
        err_cnt <= err_cnt + 16'd1;
    end
endmodule
